mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one pipelined memory port between an instruction-fetch
// requester and a data (load/store) requester. Arbitration is combinational
// and gives the data port priority. An in-order owner FIFO records who owns
// each accepted transaction, so every memory response goes back to the port
// that issued it.
//
// Optional feature (compile-time macro ARB_STARVE_GUARD_EN):
//   Counts consecutive data grants made while fetch is waiting. When the count
//   reaches STARVE_LIMIT, fetch wins the next grant. Without the macro the
//   counter does not exist and data always wins.
//
// Parameters:
//   size            address / data width
//   MAX_OUTSTANDING accepted but unanswered transactions allowed (1..4)
//   STARVE_LIMIT    consecutive data grants before fetch is forced (guard only)
//
// Ports:
//   clk, reset        clock (rising edge); asynchronous active-low reset
//   if_req/if_addr    fetch request and address
//   if_gnt            fetch request accepted this cycle
//   if_rvalid/if_rdata fetch response
//   d_req/d_we/d_addr/d_wdata/d_ctrl  data request and payload
//   d_gnt             data request accepted this cycle
//   d_rvalid/d_rdata  data response (load data or write acknowledge)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ctrl  request to memory
//   mem_gnt           memory accepts the request this cycle
//   mem_rvalid/mem_rdata  in-order response from memory
//   err_o             sticky flag: a response arrived with nothing outstanding
//
// Handshake: a requester raises req with a stable payload and holds both until
// it sees its gnt. A transfer happens in exactly the cycle where mem_req and
// mem_gnt are both high; that cycle produces the one gnt back to the owner.
// Responses carry no ready: memory returns exactly one mem_rvalid per accepted
// transaction, in acceptance order, and this block forwards it the same cycle.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int size            = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            if_req,
   input  logic [size-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [size-1:0] if_rdata,

   input  logic            d_req,
   input  logic            d_we,
   input  logic [size-1:0] d_addr,
   input  logic [size-1:0] d_wdata,
   input  logic [2:0]      d_ctrl,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [size-1:0] d_rdata,

   output logic            mem_req,
   output logic            mem_we,
   output logic [size-1:0] mem_addr,
   output logic [size-1:0] mem_wdata,
   output logic [2:0]      mem_ctrl,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [size-1:0] mem_rdata,

   output logic            err_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   // Fetch accesses are always full-word loads.
   localparam logic [2:0] FETCH_CTRL = 3'b010;

   logic [CW-1:0]              count;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [MAX_OUTSTANDING-1:0] owner_q;   // 1 = data, 0 = fetch
   logic                       err_q;

   logic full;
   logic sel_data;
   logic push;
   logic pop;
   logic head_owner;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(MAX_OUTSTANDING - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // A pop in the same cycle deliberately does not free a slot: the block
   // depends only on the registered count, keeping mem_rvalid off the
   // mem_req path.
   assign full = (count == CW'(MAX_OUTSTANDING));

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [SW-1:0] starve_cnt;
   logic          starve_hit;

   assign starve_hit = (starve_cnt >= SW'(STARVE_LIMIT));
   assign sel_data   = d_req && !(if_req && starve_hit);

   // Only data grants that made a waiting fetch wait longer are counted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (!if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt && !starve_hit) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end
`else
   logic unused_starve_limit;

   assign unused_starve_limit = (STARVE_LIMIT > 0);
   assign sel_data            = d_req;
`endif

   // Reset gates the request combinationally so nothing leaves the block
   // while reset is held, independent of the requester inputs.
   assign mem_req = reset && !full && (if_req || d_req);
   assign push    = mem_req && mem_gnt;
   assign d_gnt   = push && sel_data;
   assign if_gnt  = push && !sel_data;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = if_addr;
      mem_wdata = '0;
      mem_ctrl  = FETCH_CTRL;
      if (sel_data) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_ctrl  = d_ctrl;
      end
   end

   // Responses with nothing outstanding are dropped here and flagged below.
   assign pop        = mem_rvalid && (count != '0);
   assign head_owner = owner_q[rd_ptr];
   assign if_rvalid  = pop && !head_owner;
   assign d_rvalid   = pop && head_owner;
   assign if_rdata   = mem_rdata;
   assign d_rdata    = mem_rdata;
   assign err_o      = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         owner_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push) begin
            owner_q[wr_ptr] <= sel_data;
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (mem_rvalid && (count == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter with default parameters
// (size=32, MAX_OUTSTANDING=2, STARVE_LIMIT=4). A table of one-cycle vectors
// walks through arbitration, response routing, the outstanding limit and a
// spurious response; hand-written sequences cover starvation and reset in the
// middle of traffic. Expectations for the starvation guard follow the
// ARB_STARVE_GUARD_EN macro.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int W = 32;
   localparam logic [W-1:0] IF_ADDR = 32'h0000_0100;
   localparam logic [W-1:0] D_ADDR  = 32'h0000_0200;
   localparam logic [W-1:0] D_WDATA = 32'h5555_0000;
   localparam logic [2:0]   D_CTRL  = 3'b101;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         if_req = 1'b0;
   logic [W-1:0] if_addr = IF_ADDR;
   logic         if_gnt;
   logic         if_rvalid;
   logic [W-1:0] if_rdata;
   logic         d_req = 1'b0;
   logic         d_we = 1'b0;
   logic [W-1:0] d_addr = D_ADDR;
   logic [W-1:0] d_wdata = D_WDATA;
   logic [2:0]   d_ctrl = D_CTRL;
   logic         d_gnt;
   logic         d_rvalid;
   logic [W-1:0] d_rdata;
   logic         mem_req;
   logic         mem_we;
   logic [W-1:0] mem_addr;
   logic [W-1:0] mem_wdata;
   logic [2:0]   mem_ctrl;
   logic         mem_gnt = 1'b0;
   logic         mem_rvalid = 1'b0;
   logic [W-1:0] mem_rdata = '0;
   logic         err_o;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_ctrl     (d_ctrl),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ctrl   (mem_ctrl),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .err_o      (err_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // one cycle per vector; all state carries from one vector to the next
   typedef struct {
      string        name;
      logic         if_req;
      logic         d_req;
      logic         d_we;
      logic         mem_gnt;
      logic         mem_rvalid;
      logic [W-1:0] rdata;
      logic         exp_mem_req;
      logic         exp_if_gnt;
      logic         exp_d_gnt;
      logic         exp_if_rvalid;
      logic         exp_d_rvalid;
      logic         exp_err;
   } vec_t;

   vec_t vecs[$];

   // scoreboard of owners in acceptance order (1 = data)
   logic [0:0] exp_q[$];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req     = 1'b0;
      d_req      = 1'b0;
      d_we       = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   task automatic add(input string n, input logic ir, input logic dr, input logic we,
                      input logic g, input logic rv, input logic [W-1:0] rd,
                      input logic e_mreq, input logic e_ig, input logic e_dg,
                      input logic e_irv, input logic e_drv, input logic e_err);
      vec_t v;
      v.name = n;         v.if_req = ir;       v.d_req = dr;       v.d_we = we;
      v.mem_gnt = g;      v.mem_rvalid = rv;   v.rdata = rd;
      v.exp_mem_req = e_mreq; v.exp_if_gnt = e_ig; v.exp_d_gnt = e_dg;
      v.exp_if_rvalid = e_irv; v.exp_d_rvalid = e_drv; v.exp_err = e_err;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      // requests held during reset must not reach memory
      if_req  = 1'b1;
      d_req   = 1'b1;
      mem_gnt = 1'b1;
      #1;
      chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
      chk("reset_gnts", {30'b0, if_gnt, d_gnt}, 32'd0);
      chk("reset_rvalids", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      @(posedge clk);
      #1;
      chk("reset_err", {31'b0, err_o}, 32'd0);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   // expected grant pattern with both ports requesting continuously
   function automatic logic exp_fetch_turn(input int cyc);
`ifdef ARB_STARVE_GUARD_EN
      return (cyc % 5) == 4;
`else
      return (cyc < 0);
`endif
   endfunction

   initial begin
      logic         sel_d;
      logic [0:0]   owner;

      //                   name         if d  we g  rv rdata          mreq ig dg irv drv err
      add("idle",          0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
      add("arb_both",      1, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
      add("arb_resp",      0, 0, 0, 0, 1, 32'h0000_1234,  0, 0, 0, 0, 1, 0);
      add("route_fetch",   1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0);
      add("route_load",    0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
      add("route_rsp_a",   0, 0, 0, 0, 1, 32'h0000_AAAA,  0, 0, 0, 1, 0, 0);
      add("route_rsp_b",   0, 0, 0, 0, 1, 32'h0000_BBBB,  0, 0, 0, 0, 1, 0);
      add("full_g1",       1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0);
      add("full_g2_wr",    0, 1, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
      add("full_block",    1, 0, 0, 1, 1, 32'h0000_000C,  0, 0, 0, 1, 0, 0);
      add("full_regrant",  1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0);
      add("full_rsp_wr",   0, 0, 0, 0, 1, 32'h0000_000D,  0, 0, 0, 0, 1, 0);
      add("full_rsp_if",   0, 0, 0, 0, 1, 32'h0000_000E,  0, 0, 0, 1, 0, 0);
      add("spurious",      0, 0, 0, 0, 1, 32'h0000_000F,  0, 0, 0, 0, 0, 0);
      add("err_sticky",    0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1);
      add("no_mem_gnt",    1, 0, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 1);

      do_reset();

      // ---- table-driven vectors ----
      for (int i = 0; i < vecs.size(); i++) begin
         if_req     = vecs[i].if_req;
         d_req      = vecs[i].d_req;
         d_we       = vecs[i].d_we;
         mem_gnt    = vecs[i].mem_gnt;
         mem_rvalid = vecs[i].mem_rvalid;
         mem_rdata  = vecs[i].rdata;
         #2;
         chk({vecs[i].name, ".mem_req"},   {31'b0, mem_req},   {31'b0, vecs[i].exp_mem_req});
         chk({vecs[i].name, ".if_gnt"},    {31'b0, if_gnt},    {31'b0, vecs[i].exp_if_gnt});
         chk({vecs[i].name, ".d_gnt"},     {31'b0, d_gnt},     {31'b0, vecs[i].exp_d_gnt});
         chk({vecs[i].name, ".if_rvalid"}, {31'b0, if_rvalid}, {31'b0, vecs[i].exp_if_rvalid});
         chk({vecs[i].name, ".d_rvalid"},  {31'b0, d_rvalid},  {31'b0, vecs[i].exp_d_rvalid});
         chk({vecs[i].name, ".err_o"},     {31'b0, err_o},     {31'b0, vecs[i].exp_err});
         if (vecs[i].exp_mem_req) begin
            sel_d = vecs[i].d_req;
            chk({vecs[i].name, ".mem_addr"},  mem_addr, sel_d ? D_ADDR : IF_ADDR);
            chk({vecs[i].name, ".mem_we"},    {31'b0, mem_we}, {31'b0, sel_d & vecs[i].d_we});
            chk({vecs[i].name, ".mem_wdata"}, mem_wdata, sel_d ? D_WDATA : 32'h0);
            chk({vecs[i].name, ".mem_ctrl"},  {29'b0, mem_ctrl}, {29'b0, sel_d ? D_CTRL : 3'b010});
         end
         if (vecs[i].exp_if_rvalid) chk({vecs[i].name, ".if_rdata"}, if_rdata, vecs[i].rdata);
         if (vecs[i].exp_d_rvalid)  chk({vecs[i].name, ".d_rdata"},  d_rdata,  vecs[i].rdata);
         tick();
      end
      idle_inputs();

      // ---- starvation: both ports request continuously, one response per cycle ----
      do_reset();
      exp_q.delete();
      for (int cyc = 0; cyc < 10; cyc++) begin
         if_req     = 1'b1;
         d_req      = 1'b1;
         mem_gnt    = 1'b1;
         mem_rvalid = (cyc > 0);
         mem_rdata  = 32'(cyc);
         #2;
         owner = exp_fetch_turn(cyc) ? 1'b0 : 1'b1;
         chk($sformatf("starve_c%0d.d_gnt", cyc),  {31'b0, d_gnt},  {31'b0, owner});
         chk($sformatf("starve_c%0d.if_gnt", cyc), {31'b0, if_gnt}, {31'b0, ~owner});
         if (cyc > 0) begin
            logic [0:0] head;
            head = exp_q.pop_front();
            chk($sformatf("starve_c%0d.d_rvalid", cyc),  {31'b0, d_rvalid},  {31'b0, head});
            chk($sformatf("starve_c%0d.if_rvalid", cyc), {31'b0, if_rvalid}, {31'b0, ~head});
         end
         exp_q.push_back(owner);
         tick();
      end
      idle_inputs();
      mem_rvalid = 1'b1;
      #2;
      owner = exp_q.pop_front();
      chk("starve_drain.d_rvalid",  {31'b0, d_rvalid},  {31'b0, owner});
      chk("starve_drain.if_rvalid", {31'b0, if_rvalid}, {31'b0, ~owner});
      tick();
      mem_rvalid = 1'b0;
      #2;
      chk("starve_err", {31'b0, err_o}, 32'd0);
      tick();

      // ---- reset in the middle of traffic ----
      d_req = 1'b1; mem_gnt = 1'b1;
      #2;
      chk("midrst_g1", {31'b0, d_gnt}, 32'd1);
      tick();
      d_req = 1'b0; if_req = 1'b1;
      #2;
      chk("midrst_g2", {31'b0, if_gnt}, 32'd1);
      tick();
      if_req = 1'b0; d_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
      #1;
      chk("midrst_full", {31'b0, mem_req}, 32'd0);
      chk("midrst_pre_drv", {31'b0, d_rvalid}, 32'd1);
      reset = 1'b0;
      #1;
      chk("midrst_async_mem_req", {31'b0, mem_req}, 32'd0);
      chk("midrst_async_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
      chk("midrst_async_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      tick();
      chk("midrst_held_err", {31'b0, err_o}, 32'd0);
      chk("midrst_held_mem_req", {31'b0, mem_req}, 32'd0);
      idle_inputs();
      #1;
      reset = 1'b1;
      #1;
      if_req = 1'b1; mem_gnt = 1'b1;
      #1;
      chk("midrst_after_gnt", {31'b0, if_gnt}, 32'd1);
      chk("midrst_after_addr", mem_addr, IF_ADDR);
      tick();
      if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
      #2;
      chk("midrst_rsp_irv", {31'b0, if_rvalid}, 32'd1);
      chk("midrst_rsp_data", if_rdata, 32'h0000_0077);
      tick();
      // a late response from a transaction discarded by reset
      #1;
      chk("midrst_late_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      chk("midrst_late_err_pre", {31'b0, err_o}, 32'd0);
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("midrst_late_err", {31'b0, err_o}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
